// File: rtl/store_arbiter.sv
// Round-robin arbiter sharing one single-port line store between CPU, loader and display.
// A freeze handshake lets the loader block CPU traffic and wait for its reads to drain.
module store_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    input  logic          dsp_req,
    input  logic [AW-1:0] dsp_addr,
    output logic          dsp_gnt,
    output logic          dsp_rvalid,
    output logic [DW-1:0] rdata,
    input  logic          freeze_req,
    output logic          frozen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_dout
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, FROZEN = 2'd2} state_t;
    localparam logic [1:0] PORT_CPU = 2'd0;
    localparam logic [1:0] PORT_LD  = 2'd1;
    localparam logic [1:0] PORT_DSP = 2'd2;

    state_t          state_reg, state_next;
    logic [1:0]      ptr_reg;
    logic [2:0]      tag1_reg, tag2_reg;   // one-hot owner of the read in the issue / return stage
    logic            cpu_blocked, cpu_in_flight;
    logic [2:0]      elig, gnt_vec;
    logic [1:0]      gnt_port;
    logic            any_gnt;
    logic            g_we;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;

    assign elig = {dsp_req, ld_req, cpu_req & ~cpu_blocked} & {3{resetn}};

    // Search starts at the port after the last winner: cpu -> ld -> dsp -> cpu
    always_comb begin
        gnt_vec = 3'b000;
        case (ptr_reg)
            PORT_CPU: begin
                if (elig[1])      gnt_vec = 3'b010;
                else if (elig[2]) gnt_vec = 3'b100;
                else if (elig[0]) gnt_vec = 3'b001;
            end
            PORT_LD: begin
                if (elig[2])      gnt_vec = 3'b100;
                else if (elig[0]) gnt_vec = 3'b001;
                else if (elig[1]) gnt_vec = 3'b010;
            end
            default: begin
                if (elig[0])      gnt_vec = 3'b001;
                else if (elig[1]) gnt_vec = 3'b010;
                else if (elig[2]) gnt_vec = 3'b100;
            end
        endcase
    end

    assign any_gnt = |gnt_vec;

    always_comb begin
        gnt_port = PORT_CPU;
        g_we     = cpu_we;
        g_addr   = cpu_addr;
        g_wdata  = cpu_wdata;
        if (gnt_vec[1]) begin
            gnt_port = PORT_LD;
            g_we     = ld_we;
            g_addr   = ld_addr;
            g_wdata  = ld_wdata;
        end else if (gnt_vec[2]) begin
            gnt_port = PORT_DSP;
            g_we     = 1'b0;
            g_addr   = dsp_addr;
            g_wdata  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_reg  <= PORT_DSP;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
            mem_re   <= 1'b0;
            tag1_reg <= 3'b000;
            tag2_reg <= 3'b000;
        end else begin
            mem_we   <= any_gnt & g_we;
            mem_re   <= any_gnt & ~g_we;
            tag1_reg <= (any_gnt && !g_we) ? gnt_vec : 3'b000;
            tag2_reg <= tag1_reg;
            if (any_gnt) begin
                ptr_reg  <= gnt_port;
                mem_addr <= g_addr;
                mem_din  <= g_wdata;
            end
        end
    end

    assign cpu_in_flight = tag1_reg[0] | tag2_reg[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= RUN;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (freeze_req) state_next = DRAIN;
            DRAIN: begin
                if (!freeze_req)         state_next = RUN;
                else if (!cpu_in_flight) state_next = FROZEN;
            end
            FROZEN:  if (!freeze_req) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cpu_blocked = (state_reg != RUN);
        frozen      = (state_reg == FROZEN);
    end

    assign cpu_gnt    = gnt_vec[0];
    assign ld_gnt     = gnt_vec[1];
    assign dsp_gnt    = gnt_vec[2];
    assign cpu_rvalid = tag2_reg[0];
    assign ld_rvalid  = tag2_reg[1];
    assign dsp_rvalid = tag2_reg[2];
    assign rdata      = mem_dout;
endmodule

// File: tb/tb_store_arbiter.sv
// Bench for store_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model (winner search, shadow store, queue of due read returns).
module tb_store_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int F_RUN = 0, F_DRAIN = 1, F_FROZEN = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_req, cpu_we, ld_req, ld_we, dsp_req, freeze_req;
    logic [AW-1:0] cpu_addr, ld_addr, dsp_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata;
    logic          cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid, dsp_gnt, dsp_rvalid, frozen;
    logic [DW-1:0] rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;

    store_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid),
        .rdata(rdata), .freeze_req(freeze_req), .frozen(frozen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return (32'(i) * 32'h01010101) ^ 32'hA5A5A5A5;
    endfunction

    // Line RAM: registered addr/din/we/re, dout one cycle after re
    logic [DW-1:0] store [32];
    bit store_loaded = 1'b0;
    always @(posedge clk) begin
        if (!store_loaded) begin
            for (int i = 0; i < 32; i++) store[i] <= init_val(i);
            store_loaded <= 1'b1;
        end else begin
            if (mem_we) store[mem_addr] <= mem_din;
            if (mem_re) mem_dout <= store[mem_addr];
        end
    end

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } ret_t;

    ret_t          q[$];
    logic [31:0]   shadow [32];
    int            last, fmode, cyc, prev_kind;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic [2:0]    obs_gnt, obs_rv;
    logic [31:0]   obs_rdata;
    logic          obs_frozen;
    int            tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last      = 2;
        fmode     = F_RUN;
        prev_kind = 0;
    endtask

    // One clock cycle: compare outputs mid-cycle against the model, advance the model, step to posedge+1
    task automatic cycle();
        bit          inflight;
        int          port;
        logic [2:0]  elig, eg, er;
        logic [31:0] exp_data;
        logic        we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        ret_t        r;
        @(negedge clk);
        obs_gnt    = {dsp_gnt, ld_gnt, cpu_gnt};
        obs_rv     = {dsp_rvalid, ld_rvalid, cpu_rvalid};
        obs_rdata  = rdata;
        obs_frozen = frozen;
        chk("frozen", 32'(frozen), 32'(fmode == F_FROZEN));
        chk("mem_we", 32'(mem_we), 32'(prev_kind == 2));
        chk("mem_re", 32'(mem_re), 32'(prev_kind == 1));
        if (prev_kind != 0) chk("mem_addr", 32'(mem_addr), 32'(prev_addr));
        if (prev_kind == 2) chk("mem_din", mem_din, prev_wdata);
        inflight = 1'b0;
        foreach (q[i]) if (q[i].port == 0 && q[i].due >= cyc) inflight = 1'b1;
        er = 3'b000;
        exp_data = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            er[q[0].port] = 1'b1;
            exp_data = q[0].data;
            void'(q.pop_front());
        end
        chk("rvalid", 32'(obs_rv), 32'(er));
        if (er != 3'b000) chk("rdata", rdata, exp_data);
        elig = {dsp_req, ld_req, cpu_req && (fmode == F_RUN)};
        port = -1;
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (last + k) % 3;
            if (port < 0 && elig[p]) port = p;
        end
        eg = 3'b000;
        if (port >= 0) eg[port] = 1'b1;
        chk("gnt", 32'(obs_gnt), 32'(eg));
        prev_kind = 0;
        if (port >= 0) begin
            case (port)
                0:       begin we = cpu_we; addr = cpu_addr; wd = cpu_wdata; end
                1:       begin we = ld_we;  addr = ld_addr;  wd = ld_wdata;  end
                default: begin we = 1'b0;   addr = dsp_addr; wd = '0;        end
            endcase
            if (we) begin
                shadow[addr] = wd;
                prev_kind = 2;
            end else begin
                r.due = cyc + 2; r.port = port; r.data = shadow[addr];
                q.push_back(r);
                prev_kind = 1;
            end
            prev_addr  = addr;
            prev_wdata = wd;
            last       = port;
            $display("[TB] cyc %0d grant port %0d %s addr %0d data %08h", cyc, port,
                     we ? "wr" : "rd", addr, we ? wd : shadow[addr]);
        end
        case (fmode)
            F_RUN:   if (freeze_req) fmode = F_DRAIN;
            F_DRAIN: if (!freeze_req) fmode = F_RUN; else if (!inflight) fmode = F_FROZEN;
            default: if (!freeze_req) fmode = F_RUN;
        endcase
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = '0; ld_wdata  = '0;
        dsp_req = 1'b0; dsp_addr = '0;
    endtask

    initial begin
        int cpu_cnt, other_cnt;
        cyc = 0;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        model_reset();
        idle_inputs();
        freeze_req = 1'b0;
        resetn = 1'b0;
        cpu_req = 1'b1; cpu_addr = 5'd3;
        @(posedge clk);
        #1;
        chk("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst rvalid", 32'({dsp_rvalid, ld_rvalid, cpu_rvalid}), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_re", 32'(mem_re), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_din", mem_din, 32'd0);
        chk("rst frozen", 32'(frozen), 32'd0);

        // 1: first request after reset goes to CPU, read data two cycles later
        resetn = 1'b1;
        cycle();
        chk("t1 gnt", 32'(obs_gnt), 32'b001);
        cpu_req = 1'b0;
        cycle();
        cycle();
        chk("t1 rvalid", 32'(obs_rv), 32'b001);
        chk("t1 rdata", obs_rdata, 32'hDEADBEEF);

        // 2: fairness with all three requesting
        dsp_req = 1'b1; dsp_addr = 5'd10;
        cycle();
        cpu_req = 1'b1; cpu_addr = 5'd11;
        ld_req  = 1'b1; ld_addr  = 5'd12;
        dsp_addr = 5'd13;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("t2 gnt order %0d", i), 32'(obs_gnt), 32'(3'b001 << (i % 3)));
        end
        idle_inputs();
        cycle();
        cycle();

        // 3: write then read of same address in the next cycle
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 5'd7; ld_wdata = 32'h12345678;
        cycle();
        chk("t3 ld gnt", 32'(obs_gnt), 32'b010);
        idle_inputs();
        cpu_req = 1'b1; cpu_addr = 5'd7;
        cycle();
        chk("t3 cpu gnt", 32'(obs_gnt), 32'b001);
        cpu_req = 1'b0;
        cycle();
        cycle();
        chk("t3 rvalid", 32'(obs_rv), 32'b001);
        chk("t3 rdata", obs_rdata, 32'h12345678);

        // 4: CPU read granted as freeze_req rises; CPU then locked out, ld/dsp still served
        cpu_req = 1'b1; cpu_addr = 5'd20; freeze_req = 1'b1;
        cycle();
        chk("t4 cpu gnt", 32'(obs_gnt), 32'b001);
        cpu_addr = 5'd21;
        cpu_cnt = 0; other_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            ld_req = (k % 2 == 0); ld_addr = 5'(k);
            dsp_req = (k % 2 == 1); dsp_addr = 5'(k + 16);
            cycle();
            if (obs_gnt[0]) cpu_cnt++;
            if (obs_gnt[1] || obs_gnt[2]) other_cnt++;
            if (k == 1) begin
                chk("t4 cpu rvalid", 32'(obs_rv[0]), 32'd1);
                chk("t4 not frozen yet", 32'(obs_frozen), 32'd0);
            end
        end
        chk("t4 cpu grants", 32'(cpu_cnt), 32'd0);
        chk("t4 ld/dsp grants", 32'(other_cnt), 32'd8);
        chk("t4 frozen", 32'(obs_frozen), 32'd1);

        // 5: release freeze with a CPU request pending
        ld_req = 1'b0; dsp_req = 1'b0; freeze_req = 1'b0;
        cycle();
        chk("t5 still frozen", 32'(obs_frozen), 32'd1);
        chk("t5 no gnt", 32'(obs_gnt), 32'b000);
        cycle();
        chk("t5 unfrozen", 32'(obs_frozen), 32'd0);
        chk("t5 cpu gnt", 32'(obs_gnt), 32'b001);
        cpu_req = 1'b0;
        cycle();
        cycle();

        // 6: reset while frozen with reads in flight
        freeze_req = 1'b1;
        cpu_req = 1'b1; cpu_addr = 5'd8;
        ld_req  = 1'b1; ld_addr  = 5'd5;
        dsp_req = 1'b1; dsp_addr = 5'd6;
        for (int k = 0; k < 6; k++) cycle();
        chk("t6 frozen before reset", 32'(obs_frozen), 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6 gnt", 32'({dsp_gnt, ld_gnt, cpu_gnt}), 32'd0);
        chk("t6 rvalid", 32'({dsp_rvalid, ld_rvalid, cpu_rvalid}), 32'd0);
        chk("t6 mem_re", 32'(mem_re), 32'd0);
        chk("t6 frozen", 32'(frozen), 32'd0);
        @(posedge clk);
        #1;
        chk("t6 rvalid held", 32'({dsp_rvalid, ld_rvalid, cpu_rvalid}), 32'd0);
        model_reset();
        freeze_req = 1'b0;
        resetn = 1'b1;
        cycle();
        chk("t6 first gnt", 32'(obs_gnt), 32'b001);

        // Random traffic, including freeze toggling and withdrawn requests
        for (int k = 0; k < 500; k++) begin
            cpu_req   = ($urandom_range(0, 99) < 55);
            cpu_we    = 1'($urandom);
            cpu_addr  = 5'($urandom);
            cpu_wdata = $urandom;
            ld_req    = ($urandom_range(0, 99) < 45);
            ld_we     = 1'($urandom);
            ld_addr   = 5'($urandom);
            ld_wdata  = $urandom;
            dsp_req   = ($urandom_range(0, 99) < 50);
            dsp_addr  = 5'($urandom);
            if ($urandom_range(0, 19) == 0) freeze_req = ~freeze_req;
            cycle();
        end
        idle_inputs();
        freeze_req = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
